// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - round-robin two-port arbiter, read routing and zero-scrub for a dual-port RAM
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clear               in RUN: restart the zero-scrub of the whole RAM
//   req_valid/we        per-requester request and direction (1 = write)
//   req_addr/wdata      packed per-requester address and write data
//   req_ready           per-requester grant (combinational)
//   rsp_valid/rsp_data  per-requester read response, two cycles after acceptance
//   init_busy           scrub in progress
//   ram_*_a/b           registered RAM commands; ram_q_a/b read data, one cycle after the command
module dpram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 6,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*DW-1:0]   rsp_data,
    output logic                 init_busy,
    output logic                 ram_we_a,
    output logic                 ram_we_b,
    output logic [AW-1:0]        ram_addr_a,
    output logic [AW-1:0]        ram_addr_b,
    output logic [DW-1:0]        ram_data_a,
    output logic [DW-1:0]        ram_data_b,
    input  logic [DW-1:0]        ram_q_a,
    input  logic [DW-1:0]        ram_q_b
);

    localparam int IW = $clog2(NREQ);
    localparam int KW = AW - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   scrub_k;
    logic [IW-1:0]   rr_ptr;

    // Read tags: cmd_* travel with the registered RAM command, rsp_* line up with ram_q.
    logic            cmd_v_a, cmd_v_b, rsp_v_a, rsp_v_b;
    logic [IW-1:0]   cmd_id_a, cmd_id_b, rsp_id_a, rsp_id_b;

    logic            found_a, found_b, hazard, grant_a, grant_b, run;
    logic [IW-1:0]   idx_a, idx_b, rr_next;
    logic            we_a, we_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic [DW-1:0]   wdata_a, wdata_b;

    // Index base+off modulo NREQ; both operands are below NREQ so one subtraction suffices.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IW'(sum);
    endfunction

    // Scan from rr_ptr with wrap: first valid goes to port A, the next one to port B.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (req_valid[wrap_idx(rr_ptr, off)]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = wrap_idx(rr_ptr, off);
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = wrap_idx(rr_ptr, off);
                end
            end
        end
    end

    assign we_a    = req_we[idx_a];
    assign we_b    = req_we[idx_b];
    assign addr_a  = req_addr[int'(idx_a)*AW +: AW];
    assign addr_b  = req_addr[int'(idx_b)*AW +: AW];
    assign wdata_a = req_wdata[int'(idx_a)*DW +: DW];
    assign wdata_b = req_wdata[int'(idx_b)*DW +: DW];

    // Same address on both ports is only safe when both are reads; otherwise B waits.
    assign hazard  = (addr_a == addr_b) && (we_a || we_b);
    assign run     = (state_q == RUN);
    assign grant_a = run && found_a;
    assign grant_b = run && found_b && !hazard;
    assign rr_next = grant_b ? wrap_idx(idx_b, 1) : wrap_idx(idx_a, 1);

    always_comb begin
        req_ready = '0;
        if (grant_a) req_ready[idx_a] = 1'b1;
        if (grant_b) req_ready[idx_b] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (scrub_k == '1) state_d = RUN;
            RUN:     if (clear) state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    assign init_busy = (state_q == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            scrub_k    <= '0;
            rr_ptr     <= '0;
            ram_we_a   <= 1'b0;
            ram_we_b   <= 1'b0;
            ram_addr_a <= '0;
            ram_addr_b <= '0;
            ram_data_a <= '0;
            ram_data_b <= '0;
            cmd_v_a    <= 1'b0;
            cmd_v_b    <= 1'b0;
            cmd_id_a   <= '0;
            cmd_id_b   <= '0;
            rsp_v_a    <= 1'b0;
            rsp_v_b    <= 1'b0;
            rsp_id_a   <= '0;
            rsp_id_b   <= '0;
        end else begin
            state_q  <= state_d;
            // Tags advance regardless of state so reads issued before a clear still return.
            rsp_v_a  <= cmd_v_a;
            rsp_v_b  <= cmd_v_b;
            rsp_id_a <= cmd_id_a;
            rsp_id_b <= cmd_id_b;
            if (state_q == INIT) begin
                // Even/odd address pair per cycle; the counter wraps to 0 on the last pair.
                scrub_k    <= scrub_k + KW'(1);
                ram_we_a   <= 1'b1;
                ram_we_b   <= 1'b1;
                ram_addr_a <= {scrub_k, 1'b0};
                ram_addr_b <= {scrub_k, 1'b1};
                ram_data_a <= '0;
                ram_data_b <= '0;
                cmd_v_a    <= 1'b0;
                cmd_v_b    <= 1'b0;
                cmd_id_a   <= '0;
                cmd_id_b   <= '0;
            end else begin
                scrub_k    <= '0;
                ram_we_a   <= grant_a && we_a;
                ram_we_b   <= grant_b && we_b;
                ram_addr_a <= grant_a ? addr_a : '0;
                ram_addr_b <= grant_b ? addr_b : '0;
                ram_data_a <= (grant_a && we_a) ? wdata_a : '0;
                ram_data_b <= (grant_b && we_b) ? wdata_b : '0;
                cmd_v_a    <= grant_a && !we_a;
                cmd_v_b    <= grant_b && !we_b;
                cmd_id_a   <= idx_a;
                cmd_id_b   <= idx_b;
                if (grant_a) rr_ptr <= rr_next;
            end
        end
    end

    // A requester holds at most one port per cycle, so the two tags never target the same id.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp_v_a) begin
            rsp_valid[rsp_id_a]               = 1'b1;
            rsp_data[int'(rsp_id_a)*DW +: DW] = ram_q_a;
        end
        if (rsp_v_b) begin
            rsp_valid[rsp_id_b]               = 1'b1;
            rsp_data[int'(rsp_id_b)*DW +: DW] = ram_q_b;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - self-checking bench for dpram_arbiter with a behavioural RAM and transaction model
module tb_dpram_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int SCRUB = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic [NREQ-1:0]      req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata, rsp_data;
    logic                 init_busy, ram_we_a, ram_we_b;
    logic [AW-1:0]        ram_addr_a, ram_addr_b;
    logic [DW-1:0]        ram_data_a, ram_data_b, ram_q_a, ram_q_b;

    dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_busy(init_busy),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b), .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    typedef struct packed {logic v; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
    typedef struct {int cyc; int id; logic [DW-1:0] data;} rsp_t;
    typedef struct packed {logic [3:0] v; logic [3:0] we; logic [23:0] addr; logic [31:0] wdata; logic [3:0] ready;} vec_t;

    req_t          cur [NREQ];
    req_t          rq [NREQ][$];
    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            rr_m, init_left, prev_init, cycle, vectors, errors;
    int            rsp_cnt [NREQ];
    vec_t          tab [13];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = cur[i].v;
            req_we[i]               = cur[i].we;
            req_addr[i*AW +: AW]    = cur[i].addr;
            req_wdata[i*DW +: DW]   = cur[i].wdata;
        end
    endtask

    function automatic bit is_busy();
        bit b;
        b = (init_left != 0) || (exp_q.size() != 0);
        for (int i = 0; i < NREQ; i++) b = b || cur[i].v || (rq[i].size() != 0);
        return b;
    endfunction

    // One clock: check at the falling edge against the model, advance the model, refill requests after the edge.
    task automatic step(input bit use_tab, input logic [NREQ-1:0] tab_ready);
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic [DW-1:0]   ed [NREQ];
        int              order[$];
        int              a, b, last, k;
        @(negedge clk);
        exp_ready = '0;
        if (init_left == 0) begin
            for (int off = 0; off < NREQ; off++) begin
                int i;
                i = (rr_m + off) % NREQ;
                if (cur[i].v) order.push_back(i);
            end
            if (order.size() > 0) begin
                a = order[0];
                exp_ready[a] = 1'b1;
                last = a;
                if (order.size() > 1) begin
                    b = order[1];
                    if (!((cur[a].addr == cur[b].addr) && (cur[a].we || cur[b].we))) begin
                        exp_ready[b] = 1'b1;
                        last = b;
                    end
                end
                rr_m = (last + 1) % NREQ;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (use_tab) chk("tab_ready", 64'(req_ready), 64'(tab_ready));
        chk("init_busy", 64'(init_busy), 64'(init_left != 0));
        if (prev_init != 0) begin
            k = SCRUB - prev_init;
            chk("scrub_cmd", 64'({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b}),
                64'({1'b1, 1'b1, AW'(2*k), AW'(2*k+1), 8'h00, 8'h00}));
        end
        exp_rv = '0;
        for (int i = 0; i < NREQ; i++) ed[i] = '0;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].cyc == cycle) begin
                exp_rv[exp_q[j].id] = 1'b1;
                ed[exp_q[j].id] = exp_q[j].data;
                exp_q.delete(j);
            end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rv[i]) begin
                chk($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'(ed[i]));
                rsp_cnt[i]++;
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (exp_ready[i] && !cur[i].we) exp_q.push_back('{cycle + 2, i, ref_mem[cur[i].addr]});
        for (int i = 0; i < NREQ; i++)
            if (exp_ready[i] && cur[i].we) ref_mem[cur[i].addr] = cur[i].wdata;
        prev_init = init_left;
        if (init_left > 0) init_left--;
        else if (clear) begin
            init_left = SCRUB;
            for (int m = 0; m < DEPTH; m++) ref_mem[m] = '0;
        end
        @(posedge clk);
        cycle++;
        #1;
        for (int i = 0; i < NREQ; i++)
            if (exp_ready[i] || !cur[i].v) cur[i] = (rq[i].size() != 0) ? rq[i].pop_front() : req_t'(0);
        drive();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        cycle++;
        #1;
        rst = 1'b0;
        exp_q.delete();
        rr_m = 0;
        init_left = SCRUB;
        prev_init = 0;
        for (int m = 0; m < DEPTH; m++) ref_mem[m] = '0;
        chk("reset_outputs", 64'({init_busy, req_ready, rsp_valid, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b,
                                  ram_data_a, ram_data_b}), 64'({1'b1, 38'h0}));
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (is_busy() && n < maxc) begin
            step(1'b0, '0);
            n++;
        end
        chk("drain_done", 64'(is_busy()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; errors = 0; cycle = 0; rr_m = 0; init_left = 0; prev_init = 0;
        for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
        for (int m = 0; m < DEPTH; m++) ref_mem[m] = '0;

        // {v, we, addr{r3,r2,r1,r0}, wdata{r3,r2,r1,r0}, expected req_ready}
        tab[0]  = '{4'b1111, 4'b0000, {6'd3, 6'd2, 6'd1, 6'd0},       32'h0,         4'b0011};
        tab[1]  = '{4'b1111, 4'b0000, {6'd3, 6'd2, 6'd1, 6'd0},       32'h0,         4'b1100};
        tab[2]  = '{4'b0011, 4'b0011, {6'd0, 6'd0, 6'd5, 6'd5},       32'h00002211,  4'b0001};
        tab[3]  = '{4'b0010, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0},       32'h00002200,  4'b0010};
        tab[4]  = '{4'b0011, 4'b0000, {6'd0, 6'd0, 6'd5, 6'd5},       32'h0,         4'b0011};
        tab[5]  = '{4'b1000, 4'b0000, {6'd9, 6'd0, 6'd0, 6'd0},       32'h0,         4'b1000};
        tab[6]  = '{4'b0000, 4'b0000, 24'h0,                          32'h0,         4'b0000};
        tab[7]  = '{4'b0101, 4'b0001, {6'd0, 6'd7, 6'd0, 6'd7},       32'h00000077,  4'b0001};
        tab[8]  = '{4'b0100, 4'b0000, {6'd0, 6'd7, 6'd0, 6'd0},       32'h0,         4'b0100};
        tab[9]  = '{4'b1001, 4'b0000, {6'd7, 6'd0, 6'd0, 6'd5},       32'h0,         4'b1001};
        tab[10] = '{4'b0001, 4'b0001, {6'd0, 6'd0, 6'd0, 6'h10},      32'h000000A5,  4'b0001};
        tab[11] = '{4'b0010, 4'b0000, {6'd0, 6'd0, 6'h10, 6'd0},      32'h0,         4'b0010};
        tab[12] = '{4'b0011, 4'b0000, {6'd0, 6'd0, 6'h10, 6'h10},     32'h0,         4'b0011};

        // Reset with every requester already asking; nothing is granted until the scrub ends.
        for (int i = 0; i < NREQ; i++) cur[i] = '{1'b1, 1'b0, AW'(i), '0};
        drive();
        @(posedge clk);
        #1;
        reset_dut();
        drain(200);

        // Whole RAM reads back as zero after the scrub.
        for (int j = 0; j < DEPTH / NREQ; j++)
            for (int i = 0; i < NREQ; i++) rq[i].push_back('{1'b1, 1'b0, AW'(i + NREQ*j), '0});
        drain(200);

        // Arbitration table; rr_ptr is 0 here because every grant so far came in full 4-requester rounds.
        rr_m = 0;
        for (int t = 0; t < 13; t++) begin
            for (int i = 0; i < NREQ; i++)
                cur[i] = '{tab[t].v[i], tab[t].we[i], tab[t].addr[i*AW +: AW], tab[t].wdata[i*DW +: DW]};
            drive();
            step(1'b1, tab[t].ready);
        end
        drain(50);

        // All four read continuously; each must receive every response.
        for (int i = 0; i < NREQ; i++) begin
            rsp_cnt[i] = 0;
            for (int j = 0; j < 20; j++) rq[i].push_back('{1'b1, 1'b0, AW'($urandom_range(0, 63)), '0});
        end
        drain(200);
        for (int i = 0; i < NREQ; i++) chk($sformatf("rsp_count[%0d]", i), 64'(rsp_cnt[i]), 64'(20));

        // Randomized mix, narrow address range to provoke same-address hazards.
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 60; j++)
                rq[i].push_back('{($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                                  AW'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7)),
                                  DW'($urandom_range(0, 255))});
        drain(3000);

        // Clear with two reads in flight: both return old data, then everything reads zero.
        for (int i = 0; i < NREQ; i++) cur[i] = '{1'b1, 1'b1, AW'(3 + i), DW'(8'hC0 + i)};
        drive();
        drain(50);
        rq[2].push_back('{1'b1, 1'b0, AW'(5), '0});
        rq[3].push_back('{1'b1, 1'b0, AW'(6), '0});
        step(1'b0, '0);
        step(1'b0, '0);
        clear = 1'b1;
        step(1'b0, '0);
        clear = 1'b0;
        drain(100);
        for (int i = 0; i < NREQ; i++) rq[i].push_back('{1'b1, 1'b0, AW'(3 + i), '0});
        drain(100);

        // Reset one cycle after a read is accepted: its response must never appear.
        rq[1].push_back('{1'b1, 1'b1, AW'(6'h10), DW'(8'h5A)});
        drain(50);
        rq[0].push_back('{1'b1, 1'b0, AW'(6'h10), '0});
        step(1'b0, '0);
        step(1'b0, '0);
        reset_dut();
        drain(100);
        rq[1].push_back('{1'b1, 1'b0, AW'(6'h10), '0});
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
